// File: rtl/mem_arb_pkg.sv
// Shared types for the memory port arbiter: FSM states, read-return tag, owner-width helper.
package mem_arb_pkg;

    // Tag id is sized for the largest supported master count (8).
    localparam int OWNER_W = 3;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        OWN  = 1'b1
    } state_t;

    typedef struct packed {
        logic               vld;
        logic [OWNER_W-1:0] id;
    } tag_t;

    function automatic int owner_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/mem_port_arbiter_rr_pick.sv
// Rotating-priority picker: first requester strictly above 'last', wrapping to the lowest index.
module rr_pick #(
    parameter int N = 2,
    parameter int W = 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] last,
    output logic [W-1:0] idx,
    output logic         found
);

    logic [N-1:0] above;
    logic [N-1:0] cand;

    always_comb begin
        above = '0;
        for (int j = 0; j < N; j++) begin
            above[j] = req[j] && (W'(j) > last);
        end
        // Nobody above the last owner: wrap and take the lowest requester.
        cand = (above != '0) ? above : req;
        idx  = '0;
        for (int j = N - 1; j >= 0; j--) begin
            if (cand[j]) begin
                idx = W'(j);
            end
        end
        found = (req != '0);
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// N-master round-robin arbiter in front of a single memory port, with bounded bursts
// and an ID tag pipeline that routes read data back to the issuing master.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter  int N_MASTERS  = 2,
    parameter  int ADDR_W     = 32,
    parameter  int DATA_W     = 32,
    parameter  int MAX_BURST  = 16,
    parameter  int RD_LATENCY = 1,
    localparam int OW         = owner_w(N_MASTERS)
) (
    input  logic                          HCLK,
    input  logic                          HRESET,
    input  logic [N_MASTERS-1:0]          m_req,
    input  logic [N_MASTERS-1:0]          m_write,
    input  logic [N_MASTERS*ADDR_W-1:0]   m_addr,
    input  logic [N_MASTERS*DATA_W-1:0]   m_wdata,
    input  logic [N_MASTERS-1:0]          m_last,
    output logic [N_MASTERS-1:0]          m_gnt,
    output logic [N_MASTERS-1:0]          m_rvalid,
    output logic [DATA_W-1:0]             m_rdata,
    output logic [ADDR_W-1:0]             mem_READ_addr,
    output logic                          mem_read_flag,
    output logic [ADDR_W-1:0]             mem_WRITE_addr,
    output logic                          mem_write_flag,
    output logic [DATA_W-1:0]             mem_HWDATA,
    input  logic [DATA_W-1:0]             mem_HRDATA,
    output logic [OW-1:0]                 o_owner,
    output logic                          o_busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    state_t            state, state_d;
    logic [OW-1:0]     owner, owner_d;
    logic [OW-1:0]     last_owner, last_owner_d;
    logic [CNT_W-1:0]  beat_cnt, cnt_d;

    logic [OW-1:0]     pick_idx;
    logic              pick_found;

    logic              own_req;
    logic              own_write;
    logic              own_last;
    logic [ADDR_W-1:0] own_addr;
    logic [DATA_W-1:0] own_wdata;

    logic              accept;
    logic              burst_full;

    tag_t              tag_pipe [RD_LATENCY+1];
    tag_t              tag_out;

    rr_pick #(
        .N (N_MASTERS),
        .W (OW)
    ) u_pick (
        .req   (m_req),
        .last  (last_owner),
        .idx   (pick_idx),
        .found (pick_found)
    );

    // Route the registered owner's beat fields onto a single set of signals.
    always_comb begin
        own_req   = 1'b0;
        own_write = 1'b0;
        own_last  = 1'b0;
        own_addr  = '0;
        own_wdata = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (owner == OW'(i)) begin
                own_req   = m_req[i];
                own_write = m_write[i];
                own_last  = m_last[i];
                own_addr  = m_addr[i*ADDR_W +: ADDR_W];
                own_wdata = m_wdata[i*DATA_W +: DATA_W];
            end
        end
    end

    assign accept     = (state == OWN) && own_req;
    assign burst_full = (beat_cnt == CNT_W'(MAX_BURST - 1));

    always_comb begin
        m_gnt = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            m_gnt[i] = (state == OWN) && (owner == OW'(i)) && m_req[i];
        end
    end

    always_comb begin
        state_d      = state;
        owner_d      = owner;
        last_owner_d = last_owner;
        cnt_d        = beat_cnt;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    state_d = OWN;
                    owner_d = pick_idx;
                    cnt_d   = '0;
                end
            end
            OWN: begin
                if (accept && (beat_cnt != CNT_W'(MAX_BURST))) begin
                    cnt_d = beat_cnt + 1'b1;
                end
                // In OWN, own_req high means the beat is accepted this cycle.
                if (!own_req || own_last || burst_full) begin
                    state_d      = IDLE;
                    last_owner_d = owner;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            state      <= IDLE;
            owner      <= '0;
            last_owner <= OW'(N_MASTERS - 1);
            beat_cnt   <= '0;
        end else begin
            state      <= state_d;
            owner      <= owner_d;
            last_owner <= last_owner_d;
            beat_cnt   <= cnt_d;
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            mem_read_flag  <= 1'b0;
            mem_write_flag <= 1'b0;
            mem_READ_addr  <= '0;
            mem_WRITE_addr <= '0;
            mem_HWDATA     <= '0;
        end else begin
            mem_read_flag  <= accept && !own_write;
            mem_write_flag <= accept && own_write;
            if (accept && own_write) begin
                mem_WRITE_addr <= own_addr;
                mem_HWDATA     <= own_wdata;
            end
            if (accept && !own_write) begin
                mem_READ_addr <= own_addr;
            end
        end
    end

    // Stage 0 lines up with mem_read_flag; the extra stage covers the m_rdata register.
    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            for (int s = 0; s <= RD_LATENCY; s++) begin
                tag_pipe[s] <= '0;
            end
        end else begin
            tag_pipe[0] <= '{vld: accept && !own_write, id: OWNER_W'(owner)};
            for (int s = 1; s <= RD_LATENCY; s++) begin
                tag_pipe[s] <= tag_pipe[s-1];
            end
        end
    end

    assign tag_out = tag_pipe[RD_LATENCY];

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            m_rvalid <= '0;
            m_rdata  <= '0;
        end else begin
            for (int i = 0; i < N_MASTERS; i++) begin
                m_rvalid[i] <= tag_out.vld && (tag_out.id == OWNER_W'(i));
            end
            if (tag_out.vld) begin
                m_rdata <= mem_HRDATA;
            end
        end
    end

    assign o_owner = owner;
    assign o_busy  = (state == OWN);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed bursts, memory model, grant-trace checks.
module tb_mem_port_arbiter;

    localparam int N  = 2;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int MB = 4;
    localparam int RL = 3;
    localparam int BW = 66;   // {wr, last, addr, data}
    localparam int MW = 81;   // {cyc[15:0], wr, addr, data}
    localparam int RW = 49;   // {cyc[15:0], id, data}

    logic              HCLK;
    logic              HRESET;
    logic [N-1:0]      m_req;
    logic [N-1:0]      m_write;
    logic [N*AW-1:0]   m_addr;
    logic [N*DW-1:0]   m_wdata;
    logic [N-1:0]      m_last;
    logic [N-1:0]      m_gnt;
    logic [N-1:0]      m_rvalid;
    logic [DW-1:0]     m_rdata;
    logic [AW-1:0]     mem_READ_addr;
    logic              mem_read_flag;
    logic [AW-1:0]     mem_WRITE_addr;
    logic              mem_write_flag;
    logic [DW-1:0]     mem_HWDATA;
    logic [DW-1:0]     mem_HRDATA;
    logic [0:0]        o_owner;
    logic              o_busy;

    mem_port_arbiter #(
        .N_MASTERS  (N),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .MAX_BURST  (MB),
        .RD_LATENCY (RL)
    ) dut (
        .HCLK           (HCLK),
        .HRESET         (HRESET),
        .m_req          (m_req),
        .m_write        (m_write),
        .m_addr         (m_addr),
        .m_wdata        (m_wdata),
        .m_last         (m_last),
        .m_gnt          (m_gnt),
        .m_rvalid       (m_rvalid),
        .m_rdata        (m_rdata),
        .mem_READ_addr  (mem_READ_addr),
        .mem_read_flag  (mem_read_flag),
        .mem_WRITE_addr (mem_WRITE_addr),
        .mem_write_flag (mem_write_flag),
        .mem_HWDATA     (mem_HWDATA),
        .mem_HRDATA     (mem_HRDATA),
        .o_owner        (o_owner),
        .o_busy         (o_busy)
    );

    // ---------------- clock / reset / cycle count ----------------
    initial HCLK = 1'b0;
    always #5 HCLK = ~HCLK;

    int cyc = 0;
    always @(posedge HCLK) cyc <= cyc + 1;

    // ---------------- memory model: data appears RL cycles after the read strobe ----------------
    function automatic logic [DW-1:0] mem_fn(input logic [AW-1:0] a);
        return {a[15:0] ^ 16'h5A5A, a[15:0]};
    endfunction

    logic [AW-1:0] mp_a [RL];
    always @(posedge HCLK) begin
        mp_a[0] <= mem_READ_addr;
        for (int s = 1; s < RL; s++) mp_a[s] <= mp_a[s-1];
    end
    assign mem_HRDATA = mem_fn(mp_a[RL-1]);

    // ---------------- scoreboard state ----------------
    int checks = 0;
    int errors = 0;
    logic [MW-1:0] exp_mem_q[$];
    logic [RW-1:0] exp_rd_q[$];
    logic [BW-1:0] beat_q[N][$];
    logic [N-1:0]  acc_mask = '0;
    int            acc_at = -10;
    logic          trace_on = 1'b0;
    int            trace[$];
    int            exp_tr[$];

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic load(input int m, input logic wr, input logic last,
                        input logic [AW-1:0] addr, input logic [DW-1:0] data);
        beat_q[m].push_back({wr, last, addr, data});
    endtask

    // ---------------- driver: present queued beats, retire them on acceptance ----------------
    initial begin
        logic [BW-1:0] b;
        m_req   = '0;
        m_write = '0;
        m_last  = '0;
        m_addr  = '0;
        m_wdata = '0;
        forever begin
            @(posedge HCLK);
            #1;
            for (int i = 0; i < N; i++) begin
                if (acc_mask[i] && (acc_at == cyc - 1) && (beat_q[i].size() > 0)) begin
                    b = beat_q[i].pop_front();
                    exp_mem_q.push_back({16'(acc_at + 1), b[65], b[63:32], b[65] ? b[31:0] : 32'h0});
                    if (!b[65]) exp_rd_q.push_back({16'(acc_at + 2 + RL), 1'(i), mem_fn(b[63:32])});
                end
                if (!HRESET && (beat_q[i].size() > 0)) begin
                    b = beat_q[i][0];
                    m_req[i]              = 1'b1;
                    m_write[i]            = b[65];
                    m_last[i]             = b[64];
                    m_addr[i*AW +: AW]    = b[63:32];
                    m_wdata[i*DW +: DW]   = b[31:0];
                end else begin
                    m_req[i]   = 1'b0;
                    m_write[i] = 1'b0;
                    m_last[i]  = 1'b0;
                end
            end
        end
    end

    // ---------------- monitor: compare DUT outputs against the expected queues ----------------
    initial begin
        logic [MW-1:0] e;
        logic [RW-1:0] r;
        logic [N-1:0]  ev;
        forever begin
            @(negedge HCLK);
            acc_mask = m_req & m_gnt;
            acc_at   = cyc;
            if (trace_on && (m_req != '0))
                trace.push_back(acc_mask[1] ? 1 : (acc_mask[0] ? 0 : -1));
            if (m_gnt != '0) chk("gnt_onehot", $countones(m_gnt), 1);
            if (mem_read_flag || mem_write_flag) begin
                chk("flags_exclusive", longint'(mem_read_flag && mem_write_flag), 0);
                if (exp_mem_q.size() == 0) begin
                    chk("mem_unexpected", 1, 0);
                end else begin
                    e = exp_mem_q.pop_front();
                    chk("mem_cycle", cyc[15:0], e[80:65]);
                    chk("mem_is_write", mem_write_flag, e[64]);
                    if (e[64]) begin
                        chk("mem_write_addr", mem_WRITE_addr, e[63:32]);
                        chk("mem_hwdata", mem_HWDATA, e[31:0]);
                    end else begin
                        chk("mem_read_addr", mem_READ_addr, e[63:32]);
                    end
                end
            end
            if (m_rvalid != '0) begin
                if (exp_rd_q.size() == 0) begin
                    chk("rvalid_unexpected", m_rvalid, 0);
                end else begin
                    r  = exp_rd_q.pop_front();
                    ev = '0;
                    ev[r[32]] = 1'b1;
                    chk("rvalid_vec", m_rvalid, ev);
                    chk("rdata", m_rdata, r[31:0]);
                    chk("rvalid_cycle", cyc[15:0], r[48:33]);
                end
            end
        end
    end

    // ---------------- test helpers ----------------
    task automatic wait_idle(input string name);
        int n = 0;
        while (((beat_q[0].size() != 0) || (beat_q[1].size() != 0) ||
                (exp_mem_q.size() != 0) || (exp_rd_q.size() != 0)) && (n < 200)) begin
            @(posedge HCLK);
            n++;
        end
        chk({name, "_drained"}, longint'(n < 200), 1);
        repeat (3) @(posedge HCLK);
    endtask

    task automatic check_trace(input string name);
        chk({name, "_trace_len"}, trace.size(), exp_tr.size());
        for (int i = 0; (i < exp_tr.size()) && (i < trace.size()); i++)
            chk({name, "_trace"}, trace[i], exp_tr[i]);
        trace_on = 1'b0;
    endtask

    task automatic start_trace();
        trace.delete();
        trace_on = 1'b1;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        HRESET = 1'b1;
        repeat (2) @(posedge HCLK);
        #2;
        chk("reset_gnt", m_gnt, 0);
        chk("reset_rvalid", m_rvalid, 0);
        chk("reset_rd_flag", mem_read_flag, 0);
        chk("reset_wr_flag", mem_write_flag, 0);
        chk("reset_busy", o_busy, 0);
        chk("reset_owner", o_owner, 0);
        chk("reset_rdata", m_rdata, 0);
        @(negedge HCLK);
        HRESET = 1'b0;
        repeat (2) @(posedge HCLK);

        // Four reads from master 0, last on the fourth.
        start_trace();
        for (int k = 0; k < 4; k++) load(0, 1'b0, k == 3, 32'h100 + 4 * k, 32'h0);
        wait_idle("t1");
        exp_tr = '{-1, 0, 0, 0, 0};
        check_trace("t1");
        chk("t1_busy_after", o_busy, 0);
        chk("t1_owner_after", o_owner, 0);

        // Both masters streaming, no last: MAX_BURST splits them; last owner was 0.
        start_trace();
        for (int k = 0; k < 8; k++) begin
            load(0, k[0], 1'b0, 32'h300 + 4 * k, 32'h1000 + k);
            load(1, 1'b0, 1'b0, 32'h400 + 4 * k, 32'h0);
        end
        wait_idle("t2");
        exp_tr = '{-1, 1, 1, 1, 1, -1, 0, 0, 0, 0, -1, 1, 1, 1, 1, -1, 0, 0, 0, 0};
        check_trace("t2");

        // Single write from master 1.
        start_trace();
        load(1, 1'b1, 1'b1, 32'h2000, 32'hDEADBEEF);
        wait_idle("t3");
        exp_tr = '{-1, 1};
        check_trace("t3");
        chk("t3_owner", o_owner, 1);

        // Master 0 read then master 1 read; returns must come back in order.
        start_trace();
        load(0, 1'b0, 1'b1, 32'h500, 32'h0);
        load(1, 1'b0, 1'b1, 32'h600, 32'h0);
        wait_idle("t4");
        exp_tr = '{-1, 0, -1, 1};
        check_trace("t4");

        // Owner drops its request after two beats without last.
        start_trace();
        load(0, 1'b0, 1'b0, 32'h700, 32'h0);
        load(0, 1'b0, 1'b0, 32'h704, 32'h0);
        load(1, 1'b1, 1'b0, 32'h800, 32'hA0);
        load(1, 1'b1, 1'b1, 32'h804, 32'hA1);
        wait_idle("t5");
        exp_tr = '{-1, 0, 0, -1, -1, 1, 1};
        check_trace("t5");

        // Reset with two reads in flight.
        load(0, 1'b0, 1'b0, 32'h900, 32'h0);
        load(0, 1'b0, 1'b1, 32'h904, 32'h0);
        n = 0;
        while ((beat_q[0].size() != 0) && (n < 50)) begin
            @(posedge HCLK);
            #2;
            n++;
        end
        chk("t6_issue_bound", longint'(n < 50), 1);
        chk("t6_pre_reset_rd_flag", mem_read_flag, 1);
        HRESET = 1'b1;
        #1;
        chk("t6_rst_rd_flag", mem_read_flag, 0);
        chk("t6_rst_rd_addr", mem_READ_addr, 0);
        chk("t6_rst_rvalid", m_rvalid, 0);
        chk("t6_rst_busy", o_busy, 0);
        chk("t6_rst_gnt", m_gnt, 0);
        exp_mem_q.delete();
        exp_rd_q.delete();
        repeat (3) @(posedge HCLK);
        @(negedge HCLK);
        HRESET = 1'b0;
        repeat (10) @(posedge HCLK);
        start_trace();
        load(0, 1'b0, 1'b1, 32'hA00, 32'h0);
        load(1, 1'b0, 1'b1, 32'hB00, 32'h0);
        wait_idle("t6");
        exp_tr = '{-1, 0, -1, 1};
        check_trace("t6");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
